booth_r4_seq_ctrl: RTL and testbench

Sequential radix-4 Booth multiplier controller. It accepts a signed multiplicand/multiplier pair through a valid/ready handshake. It then steps the Booth window across the multiplier, one digit per clock: encode, select the partial product, shift it, and accumulate. The 2N-bit product is presented through a valid/ready output handshake. It is the area-optimised counterpart to the fully parallel partial-product array and exposes per-cycle encoder controls for power/debug probing.

---
 rtl/booth_pkg.sv | 33 +++
 rtl/booth_r4_seq_ctrl_if.sv | 32 +++
 rtl/booth_r4_enc.sv | 33 +++
 rtl/booth_r4_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_booth_r4_seq_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth digit decode for the radix-4 multiplier
package booth_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth digit selection: 0, +md, +2md, -md, -2md
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } sel_t;

  // Map a 3-bit overlapping multiplier window to its Booth digit
  function automatic sel_t booth_sel(input logic [2:0] window);
    sel_t s;
    case (window)
      3'b001, 3'b010: s = P1;
      3'b011:         s = P2;
      3'b100:         s = M2;
      3'b101, 3'b110: s = M1;
      default:        s = ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/booth_r4_seq_ctrl_if.sv
// rtl/booth_r4_seq_ctrl_if.sv - operand/product handshake and encoder probe bundle
interface booth_r4_seq_ctrl_if #(
  parameter int N = 32
);
  localparam int CW = $clog2(N / 2) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     md;
  logic [N-1:0]     mr;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   out;
  logic             busy;
  logic             enc_neg;
  logic             enc_two;
  logic             enc_zero;
  logic [CW-1:0]    pp_idx;

  // Operand source / product sink side
  modport master (
    output in_valid, md, mr, out_ready,
    input  in_ready, out_valid, out, busy, enc_neg, enc_two, enc_zero, pp_idx
  );

  // Multiplier controller side
  modport slave (
    input  in_valid, md, mr, out_ready,
    output in_ready, out_valid, out, busy, enc_neg, enc_two, enc_zero, pp_idx
  );

endinterface

// File: rtl/booth_r4_enc.sv
// rtl/booth_r4_enc.sv - radix-4 Booth window encoder and partial-product former
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   window,
  input  logic [N-1:0] md,
  output logic         neg,
  output logic         two,
  output logic         zero,
  output logic [N+1:0] pp
);

  sel_t         sel;
  logic [N+1:0] md_ext;
  logic [N+1:0] mag;

  // Decode the window and build the N+2-bit signed partial product; two extra
  // bits keep -2*md representable even for the most negative multiplicand
  always_comb begin
    sel    = booth_sel(window);
    neg    = (sel == M1) || (sel == M2);
    two    = (sel == P2) || (sel == M2);
    zero   = (sel == ZERO);
    md_ext = {{2{md[N-1]}}, md};
    mag    = two ? {md_ext[N:0], 1'b0} : md_ext;
    if (zero)     pp = '0;
    else if (neg) pp = -mag;
    else          pp = mag;
  end

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// rtl/booth_r4_seq_ctrl.sv - sequential radix-4 Booth multiplier, one digit per clock
module booth_r4_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  booth_r4_seq_ctrl_if.slave   bus
);

  localparam int            CW   = $clog2(N / 2) + 1;
  localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    md_q, md_d;
  logic [N:0]      mrx_q, mrx_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rdy_en_q, rdy_en_d;

  logic            in_ready_w;
  logic            accept;
  logic            enc_neg_w, enc_two_w, enc_zero_w;
  logic [N+1:0]    pp;
  logic [2*N-1:0]  pp_ext;
  logic [2*N-1:0]  pp_sh;
  logic [CW:0]     shamt;

  booth_r4_enc #(.N(N)) u_enc (
    .window (mrx_q[2:0]),
    .md     (md_q),
    .neg    (enc_neg_w),
    .two    (enc_two_w),
    .zero   (enc_zero_w),
    .pp     (pp)
  );

  // in_ready stays low through reset and rises one cycle after release
  assign in_ready_w = (state_q == IDLE) && rdy_en_q;
  assign accept     = bus.in_valid && in_ready_w;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept -> RUN for N/2 digits -> DONE until consumer takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (count_q == LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch operands on accept, accumulate each RUN cycle
  always_comb begin
    md_d     = md_q;
    mrx_d    = mrx_q;
    acc_d    = acc_q;
    count_d  = count_q;
    rdy_en_d = 1'b1;
    pp_ext   = {{(N-2){pp[N+1]}}, pp};
    shamt    = {count_q, 1'b0};
    pp_sh    = pp_ext << shamt;
    if (state_q == IDLE && accept) begin
      md_d    = bus.md;
      mrx_d   = {bus.mr, 1'b0};
      acc_d   = '0;
      count_d = '0;
    end else if (state_q == RUN) begin
      acc_d   = acc_q + pp_sh;
      mrx_d   = {mrx_q[N], mrx_q[N], mrx_q[N:2]};
      count_d = count_q + CW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_q     <= '0;
      mrx_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      md_q     <= md_d;
      mrx_q    <= mrx_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // Outputs decoded from state; encoder probes only visible while stepping
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out       = '0;
    bus.busy      = 1'b0;
    bus.enc_neg   = 1'b0;
    bus.enc_two   = 1'b0;
    bus.enc_zero  = 1'b0;
    bus.pp_idx    = '0;
    case (state_q)
      IDLE: bus.in_ready = in_ready_w;
      RUN: begin
        bus.busy     = 1'b1;
        bus.enc_neg  = enc_neg_w;
        bus.enc_two  = enc_two_w;
        bus.enc_zero = enc_zero_w;
        bus.pp_idx   = count_q;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out       = acc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// tb/tb_booth_r4_seq_ctrl.sv - self-checking bench for the sequential Booth multiplier
module tb_booth_r4_seq_ctrl;

  localparam int N     = 32;
  localparam int NRAND = 1000;

  logic clk;
  logic reset;

  booth_r4_seq_ctrl_if #(.N(N)) bus ();

  booth_r4_seq_ctrl #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [2:0]  rec_enc [0:40];
  logic [4:0]  rec_idx [0:40];
  logic [63:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 9))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Present one operand pair, wait (bounded) for out_valid, record encoder probes
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    check("in_ready_before_op", bus.in_ready, 1);
    bus.md       = a;
    bus.mr       = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      rec_enc[lat] = {bus.enc_neg, bus.enc_two, bus.enc_zero};
      rec_idx[lat] = bus.pp_idx;
      tick();
      lat++;
    end
    res = bus.out;
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    int          lat;
    int          w;
    int          sent;
    int          got;
    int          cyc;
    logic [31:0] ca;
    logic [31:0] cb;

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.md        = '0;
    bus.mr        = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();

    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out", bus.out, 0);
    check("rst_enc", {bus.enc_neg, bus.enc_two, bus.enc_zero, bus.pp_idx}, 0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", bus.in_ready, 1);

    // 3 * 5 with consumer always ready
    bus.out_ready = 1'b1;
    run_op(32'd3, 32'd5, res, lat);
    check("lat_3x5", lat, N / 2);
    check("prod_3x5", res, 64'd15);
    check("busy_done", bus.busy, 1);
    tick();
    check("hs_out_valid_low", bus.out_valid, 0);
    check("hs_in_ready", bus.in_ready, 1);
    check("hs_out_zero", bus.out, 0);

    // -7 * 6 and its first three Booth digits: -2, +2, 0
    run_op(-32'sd7, 32'd6, res, lat);
    check("prod_m7x6", res, 64'hFFFF_FFFF_FFFF_FFD6);
    check("dig0_idx", rec_idx[0], 0);
    check("dig0_enc", rec_enc[0], 3'b110);
    check("dig1_idx", rec_idx[1], 1);
    check("dig1_enc", rec_enc[1], 3'b010);
    check("dig2_idx", rec_idx[2], 2);
    check("dig2_enc", rec_enc[2], 3'b001);
    tick();

    // Extreme operands
    run_op(32'h8000_0000, 32'h8000_0000, res, lat);
    check("prod_min_min", res, 64'h4000_0000_0000_0000);
    tick();
    run_op(32'h7FFF_FFFF, 32'h8000_0000, res, lat);
    check("prod_max_min", res, 64'hC000_0000_8000_0000);
    tick();

    // Output stall: result held, in_valid pulse ignored
    bus.out_ready = 1'b0;
    run_op(32'd123456, -32'sd789, res, lat);
    held = res;
    check("prod_stall", held, ref_mul(32'd123456, -32'sd789));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.md       = 32'd5;
        bus.mr       = 32'd5;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      check("stall_out", bus.out, held);
      check("stall_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("stall_rel_valid", bus.out_valid, 0);
    check("stall_rel_in_ready", bus.in_ready, 1);
    check("stall_rel_busy", bus.busy, 0);

    // Reset while stepping digit 7
    bus.md       = 32'd1000;
    bus.mr       = 32'd2000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    w = 0;
    while (bus.pp_idx !== 5'd7 && w < 40) begin
      tick();
      w++;
    end
    check("mid_reach_idx7", bus.pp_idx, 7);
    reset = 1'b0;
    tick();
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_out", bus.out, 0);
    check("mid_rst_enc", {bus.enc_neg, bus.enc_two, bus.enc_zero, bus.pp_idx}, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    tick();
    check("mid_rst_in_ready_held", bus.in_ready, 0);
    reset = 1'b1;
    tick();
    check("mid_rel_in_ready", bus.in_ready, 1);
    check("mid_rel_no_valid", bus.out_valid, 0);
    run_op(32'd9, 32'd9, res, lat);
    check("prod_9x9", res, 64'd81);
    tick();

    // Random back-to-back traffic with random consumer stalls
    sent = 0;
    got  = 0;
    cyc  = 0;
    ca   = pick_op();
    cb   = pick_op();
    while (got < NRAND && cyc < 60000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = (sent < NRAND);
      bus.md        = ca;
      bus.mr        = cb;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_mul(ca, cb));
        sent++;
        ca = pick_op();
        cb = pick_op();
      end
      if (bus.out_valid && bus.out_ready) begin
        check("rand_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rand_prod", bus.out, exp_q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_count", got, NRAND);
    check("rand_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
